coherence_bus_ctrl: RTL and testbench
=====================================

# coherence_bus_ctrl

Dual-core data-coherence controller and memory arbiter sitting between the two per-core data caches and the single shared RAM port. It is the responder end of the cache/coherence handshake: it arbitrates cache requests, snoops the other core's cache on read misses, and forwards snoop-supplied dirty data cache-to-cache while writing it back to RAM. Writebacks and fills are serviced one word per RAM transaction.

## Interface

- No parameters. Word = 32 bits; core index i ∈ {0,1}.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dREN[i]  in  1  cache i read request (fill or snoop-read).
- dWEN[i]  in  1  cache i write request (eviction, flush or snoop writeback).
- daddr[i]  in  32  word address of cache i request.
- dstore[i]  in  32  write data from cache i.
- cctrans[i]  in  1  cache i coherence transaction flag (miss fill, or snoop response).
- ccwrite[i]  in  1  on a miss: requester intends to write (invalidate others); on a snoop response: snooped block is dirty, writeback follows.
- dwait[i]  out  1  1 = cache i request not complete this cycle.
- dload[i]  out  32  read data to cache i, valid when dwait[i]=0.
- ccwait[i]  out  1  snoop pending for cache i.
- ccinv[i]  out  1  snooped block must be invalidated.
- ccsnoopaddr[i]  out  32  address being snooped in cache i.
- ramREN, ramWEN  out  1  RAM read/write strobes.
- ramaddr, ramstore  out  32  RAM address/write data.
- ramload  in  32  RAM read data.
- ram_wait  in  1  1 = RAM access not finished this cycle.

## Operation

- Reset values: all dwait=1, dload=0, ccwait=0, ccinv=0, ccsnoopaddr=0, ramREN=ramWEN=0, ramaddr=ramstore=0; state IDLE; last_grant=1 (core 0 wins first tie).
- States: IDLE, WB, SNOOP, C2C, FILL.
- IDLE: request[i] = dREN[i]|dWEN[i]. Grant: sole requester, else core ≠ last_grant. Register req = grant, update last_grant. Next: dWEN & ~cctrans → WB; dREN & cctrans → SNOOP; dREN & ~cctrans → FILL. Zero-cycle grant: outputs of new state appear the following cycle.
- WB: ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req]; dwait[req]=ram_wait. Stay while dWEN[req]=1 (one word per completed access, cache advances its address); return to IDLE when dWEN[req]=0.
- SNOOP: o = ~req. ccwait[o]=1, ccsnoopaddr[o]=daddr[req], ccinv[o]=ccwrite[req]. dwait[req]=1. Wait for cctrans[o]=1: ccwrite[o]=1 → C2C; else → FILL. ccsnoopaddr/ccinv held constant while in SNOOP and C2C.
- C2C: ccwait[o] held 1. ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o]; when ram_wait=0: dwait[o]=0 and, if dREN[req] with daddr[req]==daddr[o], dload[req]=dstore[o], dwait[req]=0. Leave to FILL when dWEN[o] drops (remaining requester words read from RAM, now coherent); to IDLE if dREN[req] also dropped.
- FILL: ramREN=1, ramaddr=daddr[req], dload[req]=ramload, dwait[req]=ram_wait. Return to IDLE when dREN[req]=0.
- Non-granted core: dwait=1, dload=0 at all times.
- A core already snooped (ccwait=1) may not be granted until it leaves SNOOP/C2C; simultaneous misses from both cores serialize by round-robin, never deadlock.
- Both ramREN and ramWEN never asserted together.

## Timing

- Request → first RAM strobe: 1 cycle (IDLE grant) plus snoop response latency.
- Each word completes in the cycle ram_wait=0; dwait low exactly that cycle, dload valid same cycle.
- Snoop response latency unbounded; controller waits in SNOOP indefinitely.
- Request dropped mid-transaction (dREN/dWEN fall) → IDLE next cycle, no RAM strobe that cycle.
- rst asserted in any state → all outputs to reset values immediately; no partial-word completion signalled.

## Test plan

- Core 0 writeback of 0xDEAD0000/0xDEAD0001 to 0x100/0x104, ram_wait=1 for 2 cycles each → two ramWEN words, dwait[0] low once per word, IDLE after dWEN falls.
- Core 1 read miss 0x200 (cctrans=1, ccwrite=0), core 0 responds clean → ccwait[0]=1, ccsnoopaddr[0]=0x200, ccinv[0]=0; fill from RAM, dload[1]=ramload.
- Core 0 write miss 0x300 (ccwrite=1), core 1 dirty 0xBEEF → ccinv[1]=1; C2C: ramWEN with 0xBEEF to 0x300 and dload[0]=0xBEEF same cycle.
- Both cores request same cycle after reset, then again → core 0 granted first, core 1 second, core 0 on third tie.
- rst pulsed during C2C with ram_wait=1 → dwait=1, ccwait=0, ramWEN=0 immediately; next request serviced normally.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// Dual-core coherence controller and shared-RAM arbiter: round-robin grant,
// snoop of the peer cache on coherent misses, cache-to-cache forwarding with writeback.
module coherence_bus_ctrl (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ram_wait
);

  typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, FILL} state_t;

  state_t      state, state_n;
  logic        req, req_n;
  logic        last_grant, last_grant_n;
  logic [31:0] snoop_addr, snoop_addr_n;
  logic        snoop_inv, snoop_inv_n;
  logic [1:0]  request;
  logic        grant;
  logic        oth;

  assign oth = ~req;

  // A plain snoop writeback with no pending snoop cannot be serviced, so it never competes
  assign request = dREN | (dWEN & ~cctrans);
  assign grant   = (&request) ? ~last_grant : request[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req        <= 1'b0;
      last_grant <= 1'b1;
      snoop_addr <= '0;
      snoop_inv  <= 1'b0;
    end else begin
      state      <= state_n;
      req        <= req_n;
      last_grant <= last_grant_n;
      snoop_addr <= snoop_addr_n;
      snoop_inv  <= snoop_inv_n;
    end
  end

  // Next-state and grant bookkeeping
  always_comb begin
    state_n      = state;
    req_n        = req;
    last_grant_n = last_grant;
    snoop_addr_n = snoop_addr;
    snoop_inv_n  = snoop_inv;
    case (state)
      IDLE: begin
        if (|request) begin
          if (dWEN[grant] && !cctrans[grant]) state_n = WB;
          else if (cctrans[grant])             state_n = SNOOP;
          else                                 state_n = FILL;
          req_n        = grant;
          last_grant_n = grant;
          snoop_addr_n = daddr[grant];
          snoop_inv_n  = ccwrite[grant];
        end
      end
      WB:    if (!dWEN[req]) state_n = IDLE;
      SNOOP: begin
        if (!dREN[req])        state_n = IDLE;
        else if (cctrans[oth]) state_n = ccwrite[oth] ? C2C : FILL;
      end
      C2C:   if (!dWEN[oth]) state_n = dREN[req] ? FILL : IDLE;
      FILL:  if (!dREN[req]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs follow the registered state and the live cache/RAM inputs
  always_comb begin
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      WB: begin
        ramWEN     = dWEN[req];
        ramaddr    = daddr[req];
        ramstore   = dstore[req];
        dwait[req] = ram_wait | ~dWEN[req];
      end
      SNOOP: begin
        ccwait[oth]      = 1'b1;
        ccsnoopaddr[oth] = snoop_addr;
        ccinv[oth]       = snoop_inv;
      end
      C2C: begin
        ccwait[oth]      = 1'b1;
        ccsnoopaddr[oth] = snoop_addr;
        ccinv[oth]       = snoop_inv;
        ramWEN           = dWEN[oth];
        ramaddr          = daddr[oth];
        ramstore         = dstore[oth];
        if (dWEN[oth] && !ram_wait) begin
          dwait[oth] = 1'b0;
          // Forward the dirty word straight to the requester when it wants the same word
          if (dREN[req] && (daddr[req] == daddr[oth])) begin
            dload[req] = dstore[oth];
            dwait[req] = 1'b0;
          end
        end
      end
      FILL: begin
        ramREN     = dREN[req];
        ramaddr    = daddr[req];
        dload[req] = ramload;
        dwait[req] = ram_wait | ~dREN[req];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: writeback, snooped fill, cache-to-cache
// forwarding, reset during C2C and round-robin ties.
module tb_coherence_bus_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0] daddr, dstore;
  logic [1:0]       dwait, ccwait, ccinv;
  logic [1:0][31:0] dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic             ram_wait;

  int checks = 0;
  int errors = 0;

  coherence_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_wait(ram_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    daddr = '0; dstore = '0; ramload = '0; ram_wait = 1'b0;
  endtask

  task automatic no_both_strobes(input string tag);
    chk(tag, 32'(ramREN & ramWEN), 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #3;
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_dload", dload[0] | dload[1], 32'h0);
    chk("rst_ccwait", 32'({ccwait, ccinv}), 32'h0);
    chk("rst_ram", 32'({ramREN, ramWEN}), 32'h0);
    chk("rst_ramaddr", ramaddr | ramstore, 32'h0);
    chk("rst_snoopaddr", ccsnoopaddr[0] | ccsnoopaddr[1], 32'h0);
    tick();
    rst = 1'b0;

    // ---- core 0 writeback, two words, ram_wait high for 2 cycles each ----
    dWEN[0] = 1'b1; daddr[0] = 32'h100; dstore[0] = 32'hDEAD0000; ram_wait = 1'b1;
    settle();
    chk("wb_idle_ramwen", 32'(ramWEN), 32'd0);
    chk("wb_idle_dwait", 32'(dwait), 32'h3);
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        ram_wait = (c == 2) ? 1'b0 : 1'b1;
        settle();
        chk("wb_ramwen", 32'(ramWEN), 32'd1);
        chk("wb_ramaddr", ramaddr, (w == 0) ? 32'h100 : 32'h104);
        chk("wb_ramstore", ramstore, (w == 0) ? 32'hDEAD0000 : 32'hDEAD0001);
        chk("wb_dwait", 32'(dwait), (c == 2) ? 32'h2 : 32'h3);
        no_both_strobes("wb_excl");
      end
      daddr[0] = 32'h104; dstore[0] = 32'hDEAD0001; ram_wait = 1'b1;
    end
    tick();
    dWEN[0] = 1'b0; ram_wait = 1'b0;
    settle();
    chk("wb_drop_ramwen", 32'(ramWEN), 32'd0);
    chk("wb_drop_dwait", 32'(dwait), 32'h3);
    tick();
    settle();
    chk("wb_idle_after", 32'({ramREN, ramWEN, dwait}), 32'h3);

    // ---- core 1 read miss 0x200, core 0 responds clean, fill from RAM ----
    clear_inputs();
    dREN[1] = 1'b1; cctrans[1] = 1'b1; daddr[1] = 32'h200;
    settle();
    chk("rm_idle_ccwait", 32'(ccwait), 32'h0);
    tick();
    settle();
    chk("rm_ccwait", 32'(ccwait), 32'h1);
    chk("rm_snoopaddr0", ccsnoopaddr[0], 32'h200);
    chk("rm_snoopaddr1", ccsnoopaddr[1], 32'h0);
    chk("rm_ccinv", 32'(ccinv), 32'h0);
    chk("rm_dwait", 32'(dwait), 32'h3);
    chk("rm_noram", 32'({ramREN, ramWEN}), 32'h0);
    tick();
    cctrans[0] = 1'b1; ccwrite[0] = 1'b0;
    settle();
    chk("rm_wait_ccwait", 32'(ccwait), 32'h1);
    tick();
    cctrans[0] = 1'b0; ram_wait = 1'b0; ramload = 32'h12345678;
    settle();
    chk("rm_fill_ramren", 32'(ramREN), 32'd1);
    chk("rm_fill_ramaddr", ramaddr, 32'h200);
    chk("rm_fill_dload1", dload[1], 32'h12345678);
    chk("rm_fill_dload0", dload[0], 32'h0);
    chk("rm_fill_dwait", 32'(dwait), 32'h1);
    chk("rm_fill_ccwait", 32'(ccwait), 32'h0);
    no_both_strobes("rm_excl");
    tick();
    dREN[1] = 1'b0;
    settle();
    chk("rm_drop_ramren", 32'(ramREN), 32'd0);
    tick();

    // ---- core 0 write miss 0x300, core 1 dirty, cache-to-cache ----
    clear_inputs();
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h300;
    tick();
    settle();
    chk("wm_ccwait", 32'(ccwait), 32'h2);
    chk("wm_snoopaddr1", ccsnoopaddr[1], 32'h300);
    chk("wm_ccinv", 32'(ccinv), 32'h2);
    tick();
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1;
    settle();
    chk("wm_resp_ramwen", 32'(ramWEN), 32'd0);
    tick();
    dWEN[1] = 1'b1; daddr[1] = 32'h300; dstore[1] = 32'hBEEF; ram_wait = 1'b1;
    settle();
    chk("c2c_ramwen", 32'(ramWEN), 32'd1);
    chk("c2c_ramaddr", ramaddr, 32'h300);
    chk("c2c_ramstore", ramstore, 32'hBEEF);
    chk("c2c_wait_dwait", 32'(dwait), 32'h3);
    chk("c2c_ccwait", 32'(ccwait), 32'h2);
    chk("c2c_ccinv", 32'(ccinv), 32'h2);
    chk("c2c_snoopaddr", ccsnoopaddr[1], 32'h300);
    tick();
    ram_wait = 1'b0;
    settle();
    chk("c2c_done_dwait", 32'(dwait), 32'h0);
    chk("c2c_dload0", dload[0], 32'hBEEF);
    chk("c2c_dload1", dload[1], 32'h0);
    no_both_strobes("c2c_excl");

    // ---- reset pulse while C2C is stalled on RAM ----
    tick();
    ram_wait = 1'b1;
    settle();
    chk("c2c_pre_rst_ramwen", 32'(ramWEN), 32'd1);
    rst = 1'b1;
    #1;
    chk("c2c_rst_dwait", 32'(dwait), 32'h3);
    chk("c2c_rst_ccwait", 32'(ccwait), 32'h0);
    chk("c2c_rst_ccinv", 32'(ccinv), 32'h0);
    chk("c2c_rst_ramwen", 32'(ramWEN), 32'd0);
    chk("c2c_rst_dload", dload[0], 32'h0);
    tick();
    rst = 1'b0;
    clear_inputs();
    dREN[1] = 1'b1; daddr[1] = 32'h400;
    tick();
    ramload = 32'hCAFE;
    settle();
    chk("post_rst_ramren", 32'(ramREN), 32'd1);
    chk("post_rst_ramaddr", ramaddr, 32'h400);
    chk("post_rst_dload1", dload[1], 32'hCAFE);
    chk("post_rst_dwait", 32'(dwait), 32'h1);
    tick();
    dREN[1] = 1'b0;
    tick();

    // ---- round-robin ties after a fresh reset ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600; ramload = 32'h55;
    tick();
    settle();
    chk("tie1_ramaddr", ramaddr, 32'h500);
    chk("tie1_dwait", 32'(dwait), 32'h2);
    tick();
    dREN[0] = 1'b0;
    settle();
    chk("tie1_drop_ramren", 32'(ramREN), 32'd0);
    tick();
    dREN[0] = 1'b1;
    tick();
    settle();
    chk("tie2_ramaddr", ramaddr, 32'h600);
    chk("tie2_dwait", 32'(dwait), 32'h1);
    chk("tie2_dload1", dload[1], 32'h55);
    tick();
    dREN[1] = 1'b0;
    tick();
    dREN[1] = 1'b1;
    tick();
    settle();
    chk("tie3_ramaddr", ramaddr, 32'h500);
    chk("tie3_dwait", 32'(dwait), 32'h2);
    chk("tie3_dload0", dload[0], 32'h55);
    tick();
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
